// File: rtl/fp_unpack.sv
// Two-stage FP operand front-end: NaN-box check, field split, fclass vectors and
// sign-magnitude extended operands behind a valid/ready pipeline with flush.
module fp_unpack #(
  parameter bit          CHECK_BOX   = 1'b1,
  parameter logic [31:0] CANON_NAN_S = 32'h7fc00000
) (
  input  logic        fp_unpack_i_clk,
  input  logic        fp_unpack_i_rst_n,
  input  logic        fp_unpack_i_flush,
  input  logic        fp_unpack_i_valid,
  output logic        fp_unpack_o_ready,
  input  logic [63:0] fp_unpack_i_data1,
  input  logic [63:0] fp_unpack_i_data2,
  input  logic [1:0]  fp_unpack_i_fmt,
  input  logic [2:0]  fp_unpack_i_rm,
  output logic        fp_unpack_o_valid,
  input  logic        fp_unpack_i_ready,
  output logic [63:0] fp_unpack_o_data1,
  output logic [63:0] fp_unpack_o_data2,
  output logic [64:0] fp_unpack_o_ext1,
  output logic [64:0] fp_unpack_o_ext2,
  output logic [9:0]  fp_unpack_o_class1,
  output logic [9:0]  fp_unpack_o_class2,
  output logic [1:0]  fp_unpack_o_fmt,
  output logic [2:0]  fp_unpack_o_rm
);

  typedef struct packed {
    logic [63:0] word;
    logic        sign;
    logic        exp_ones;
    logic        exp_zero;
    logic        man_zero;
    logic        man_msb;
  } op_t;

  function automatic op_t unpack_op(input logic [63:0] d, input logic single);
    op_t o;
    o = '0;
    if (single) begin
      if (CHECK_BOX && (d[63:32] != 32'hffff_ffff))
        o.word = {32'h0, CANON_NAN_S};
      else
        o.word = {32'h0, d[31:0]};
      o.sign     = o.word[31];
      o.exp_ones = &o.word[30:23];
      o.exp_zero = ~|o.word[30:23];
      o.man_zero = ~|o.word[22:0];
      o.man_msb  = o.word[22];
    end else begin
      o.word     = d;
      o.sign     = d[63];
      o.exp_ones = &d[62:52];
      o.exp_zero = ~|d[62:52];
      o.man_zero = ~|d[51:0];
      o.man_msb  = d[51];
    end
    return o;
  endfunction

  // NaN sign is irrelevant to the class; both NaN kinds sit in bits 8/9.
  function automatic logic [9:0] classify(input op_t o);
    logic [9:0] c;
    c = '0;
    if (o.exp_ones) begin
      if (o.man_zero)    c = o.sign ? 10'h001 : 10'h080;
      else if (o.man_msb) c = 10'h200;
      else               c = 10'h100;
    end else if (o.exp_zero) begin
      if (o.man_zero)    c = o.sign ? 10'h008 : 10'h010;
      else               c = o.sign ? 10'h004 : 10'h020;
    end else begin
      c = o.sign ? 10'h002 : 10'h040;
    end
    return c;
  endfunction

  function automatic logic [64:0] extend(input op_t o, input logic single);
    logic [64:0] e;
    if (single) e = {o.sign, 33'h0, o.word[30:0]};
    else        e = {o.sign, 1'b0, o.word[62:0]};
    return e;
  endfunction

  logic       s1_valid;
  op_t        s1_op1;
  op_t        s1_op2;
  logic [1:0] s1_fmt;
  logic [2:0] s1_rm;
  logic       s1_single;
  logic       in_single;
  logic       s2_adv;
  logic       s1_adv;
  logic       accept;

  assign s2_adv            = !fp_unpack_o_valid || fp_unpack_i_ready;
  assign s1_adv            = !s1_valid || s2_adv;
  assign fp_unpack_o_ready = s1_adv && !fp_unpack_i_flush;
  assign accept            = fp_unpack_i_valid && fp_unpack_o_ready;
  assign in_single         = (fp_unpack_i_fmt == 2'd0);
  assign s1_single         = (s1_fmt == 2'd0);

  always_ff @(posedge fp_unpack_i_clk or negedge fp_unpack_i_rst_n) begin
    if (!fp_unpack_i_rst_n) begin
      s1_valid          <= 1'b0;
      fp_unpack_o_valid <= 1'b0;
    end else if (fp_unpack_i_flush) begin
      s1_valid          <= 1'b0;
      fp_unpack_o_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid          <= accept;
      if (s2_adv) fp_unpack_o_valid <= s1_valid;
    end
  end

  always_ff @(posedge fp_unpack_i_clk or negedge fp_unpack_i_rst_n) begin
    if (!fp_unpack_i_rst_n) begin
      s1_op1 <= '0;
      s1_op2 <= '0;
      s1_fmt <= '0;
      s1_rm  <= '0;
    end else if (accept) begin
      s1_op1 <= unpack_op(fp_unpack_i_data1, in_single);
      s1_op2 <= unpack_op(fp_unpack_i_data2, in_single);
      s1_fmt <= fp_unpack_i_fmt;
      s1_rm  <= fp_unpack_i_rm;
    end
  end

  // Output flops only move when a live S1 entry advances, so a stalled result holds.
  always_ff @(posedge fp_unpack_i_clk or negedge fp_unpack_i_rst_n) begin
    if (!fp_unpack_i_rst_n) begin
      fp_unpack_o_data1  <= '0;
      fp_unpack_o_data2  <= '0;
      fp_unpack_o_ext1   <= '0;
      fp_unpack_o_ext2   <= '0;
      fp_unpack_o_class1 <= '0;
      fp_unpack_o_class2 <= '0;
      fp_unpack_o_fmt    <= '0;
      fp_unpack_o_rm     <= '0;
    end else if (s2_adv && s1_valid && !fp_unpack_i_flush) begin
      fp_unpack_o_data1  <= s1_op1.word;
      fp_unpack_o_data2  <= s1_op2.word;
      fp_unpack_o_ext1   <= extend(s1_op1, s1_single);
      fp_unpack_o_ext2   <= extend(s1_op2, s1_single);
      fp_unpack_o_class1 <= classify(s1_op1);
      fp_unpack_o_class2 <= classify(s1_op2);
      fp_unpack_o_fmt    <= s1_fmt;
      fp_unpack_o_rm     <= s1_rm;
    end
  end

endmodule
